turn_signal_controller: RTL

//  Front-end controller for the T-Bird tail-light FSM. Debounces the raw Left/Right/Hazard switches and arbitrates them into one mode.

---
 rtl/turn_signal_controller.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/turn_signal_controller.sv
// -----------------------------------------------------------------------------
// turn_signal_controller
//
// Front-end for the T-Bird tail-light FSM. It synchronizes and debounces the
// raw Left/Right/Hazard switches and arbitrates them into a single mode. It
// also produces the step-enable tick that paces the light sequence. The mode
// only moves on tick edges. Any change between incompatible modes is routed
// through a DRAIN interval with every request low, so the light FSM always
// returns to IDLE before starting a new pattern.
//
// Parameters
//   STEP_DIV     clock cycles per light step (>= 2), period of StepEn
//   DEBOUNCE     consecutive stable synchronized cycles to accept a change (>= 1)
//   DRAIN_STEPS  steps spent with all requests low between modes (>= 1)
//
// Ports
//   Clock     in   single clock, rising edge
//   ClearN    in   asynchronous active-low clear
//   LeftSw    in   raw left switch (asynchronous)
//   RightSw   in   raw right switch (asynchronous)
//   HazardSw  in   raw hazard switch (asynchronous)
//   StepEn    out  one-cycle tick every STEP_DIV cycles
//   Left      out  left request to the light FSM
//   Right     out  right request to the light FSM
//   Hazard    out  hazard request to the light FSM
//   Busy      out  high whenever the mode is not IDLE
// -----------------------------------------------------------------------------
module turn_signal_controller #(
  parameter int STEP_DIV    = 8,
  parameter int DEBOUNCE    = 4,
  parameter int DRAIN_STEPS = 3
) (
  input  logic Clock,
  input  logic ClearN,
  input  logic LeftSw,
  input  logic RightSw,
  input  logic HazardSw,
  output logic StepEn,
  output logic Left,
  output logic Right,
  output logic Hazard,
  output logic Busy
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int DW = $clog2(DRAIN_STEPS) + 1;
  localparam int CW = $clog2(DEBOUNCE) + 1;

  typedef enum logic [2:0] {
    MODE_IDLE,
    MODE_LEFT,
    MODE_RIGHT,
    MODE_HAZ,
    MODE_DRAIN
  } mode_e;

  // ---------------------------------------------------------------------------
  // Input path: two-flop synchronizer and debounce filter for each switch.
  // Bit 0 is left, bit 1 is right, bit 2 is hazard.
  // ---------------------------------------------------------------------------
  logic [2:0] raw_sw;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] filt_q;

  assign raw_sw = {HazardSw, RightSw, LeftSw};

  // NOTE: sequential state uses non-blocking assignments, so every flop samples
  // the pre-edge values and the order of statements cannot create a race.
  always_ff @(posedge Clock or negedge ClearN) begin
    if (!ClearN) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_sw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_debounce
    logic [CW-1:0] cnt_q;

    // A change is accepted on the DEBOUNCE-th consecutive cycle of mismatch.
    // Any cycle of agreement restarts the count, so short glitches are dropped.
    always_ff @(posedge Clock or negedge ClearN) begin
      if (!ClearN) begin
        cnt_q     <= '0;
        filt_q[g] <= 1'b0;
      end else if (sync2_q[g] == filt_q[g]) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
        cnt_q     <= '0;
        filt_q[g] <= sync2_q[g];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Step prescaler: free-running counter. The tick is asserted in its last count.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pcnt_q;

  always_ff @(posedge Clock or negedge ClearN) begin
    if (!ClearN) begin
      pcnt_q <= '0;
    end else if (pcnt_q == PW'(STEP_DIV - 1)) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + PW'(1);
    end
  end

  assign StepEn = (pcnt_q == PW'(STEP_DIV - 1));

  // ---------------------------------------------------------------------------
  // Mode arbitration: evaluated only on tick edges.
  // ---------------------------------------------------------------------------
  mode_e         mode_q, mode_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          left_q, right_q, hazard_q;
  logic          f_left, f_right, f_haz, want_haz;

  assign f_left   = filt_q[0];
  assign f_right  = filt_q[1];
  assign f_haz    = filt_q[2];
  // Both turn switches together are treated as a hazard request.
  assign want_haz = f_haz | (f_left & f_right);

  // NOTE: every signal driven here gets a default value first. Any path that
  // leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    mode_d = mode_q;
    dcnt_d = dcnt_q;
    if (StepEn) begin
      unique case (mode_q)
        MODE_IDLE: begin
          if (want_haz)     mode_d = MODE_HAZ;
          else if (f_left)  mode_d = MODE_LEFT;
          else if (f_right) mode_d = MODE_RIGHT;
        end
        MODE_LEFT: begin
          if (want_haz)                 mode_d = MODE_HAZ;
          else if (!(f_left & !f_right)) mode_d = MODE_DRAIN;
        end
        MODE_RIGHT: begin
          if (want_haz)                 mode_d = MODE_HAZ;
          else if (!(f_right & !f_left)) mode_d = MODE_DRAIN;
        end
        MODE_HAZ: begin
          if (!want_haz) mode_d = MODE_DRAIN;
        end
        MODE_DRAIN: begin
          // A hazard request cuts the drain short.
          if (want_haz)                mode_d = MODE_HAZ;
          else if (dcnt_q == DW'(0))   mode_d = MODE_IDLE;
          else                         dcnt_d = dcnt_q - DW'(1);
        end
        default: mode_d = MODE_IDLE;
      endcase
      // Entering DRAIN loads the count, so DRAIN lasts DRAIN_STEPS ticks.
      if (mode_d == MODE_DRAIN && mode_q != MODE_DRAIN) begin
        dcnt_d = DW'(DRAIN_STEPS - 1);
      end
    end
  end

  // Outputs are registered from the next mode. They change on the tick edge
  // and then hold steady for the whole step.
  always_ff @(posedge Clock or negedge ClearN) begin
    if (!ClearN) begin
      mode_q   <= MODE_IDLE;
      dcnt_q   <= '0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      hazard_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      dcnt_q   <= dcnt_d;
      left_q   <= (mode_d == MODE_LEFT);
      right_q  <= (mode_d == MODE_RIGHT);
      hazard_q <= (mode_d == MODE_HAZ);
    end
  end

  assign Left   = left_q;
  assign Right  = right_q;
  assign Hazard = hazard_q;
  assign Busy   = (mode_q != MODE_IDLE);

endmodule
